// File: rtl/rgu_result_fifo_if.sv
// Bus between the RGU push path / UART host bridge and the result FIFO.
// Signal names keep the RGU's iX/oX spelling so they trace to the FIFO's pins.
interface rgu_result_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  iEnable;
  logic                  iFifoPush;
  logic [DATA_WIDTH-1:0] iFifoData;
  logic                  iUartSelected;
  logic                  iUartWrite;
  logic [7:0]            iUartAddr;
  logic [DATA_WIDTH-1:0] iUartData;
  logic [DATA_WIDTH-1:0] oUartData;
  logic                  oFifoFull;
  logic                  oFifoNotEmpty;

  modport master (
    output iEnable, iFifoPush, iFifoData, iUartSelected, iUartWrite, iUartAddr, iUartData,
    input  oUartData, oFifoFull, oFifoNotEmpty
  );

  modport slave (
    input  iEnable, iFifoPush, iFifoData, iUartSelected, iUartWrite, iUartAddr, iUartData,
    output oUartData, oFifoFull, oFifoNotEmpty
  );
endinterface

// File: rtl/rgu_result_fifo.sv
// Circular buffer capturing RGU push results, drained by the host over the UART
// register protocol (DATA pop, STATUS, CONTROL flush/clear, PUSHCNT).
module rgu_result_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input logic              iClock,
  input logic              iReset,
  rgu_result_fifo_if.slave bus
);
  localparam int unsigned Depth  = 1 << DEPTH_LOG2;
  localparam int unsigned CountW = DEPTH_LOG2 + 1;

  localparam logic [7:0] AddrData    = 8'h00;
  localparam logic [7:0] AddrStatus  = 8'h01;
  localparam logic [7:0] AddrControl = 8'h02;
  localparam logic [7:0] AddrPushCnt = 8'h03;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DEPTH_LOG2-1:0] wrPtrQ, rdPtrQ;
  logic [CountW-1:0]     countQ, countD;
  logic [DATA_WIDTH-1:0] pushCntQ;
  logic                  overflowQ, underflowQ;
  logic                  selQ, armedQ;
  logic [DATA_WIDTH-1:0] rdDataQ, uartDataQ;
  logic                  rdPendQ;
  logic                  fullQ, notEmptyQ;

  logic                  strobe, rdStrobe, wrStrobe;
  logic                  empty, full;
  logic                  pushReq, popReq, popOk, pushOk;
  logic                  flush, clear, overflowSet, underflowSet;
  logic [DATA_WIDTH-1:0] statusWord, rdWord;

  // armedQ blocks a strobe until select has been seen low, so a select held
  // high across reset does not fire an access.
  assign strobe   = bus.iUartSelected & ~selQ & armedQ;
  assign rdStrobe = strobe & ~bus.iUartWrite;
  assign wrStrobe = strobe & bus.iUartWrite;

  assign empty = (countQ == '0);
  assign full  = (countQ == CountW'(Depth));

  assign pushReq      = bus.iEnable & bus.iFifoPush;
  assign popReq       = rdStrobe & (bus.iUartAddr == AddrData);
  assign popOk        = popReq & ~empty;
  assign underflowSet = popReq & empty;
  assign flush        = wrStrobe & (bus.iUartAddr == AddrControl) & bus.iUartData[0];
  assign clear        = wrStrobe & (bus.iUartAddr == AddrControl) & bus.iUartData[1];
  assign pushOk       = pushReq & (~full | popOk) & ~flush;
  assign overflowSet  = pushReq & full & ~popOk & ~flush;

  always_comb begin
    countD = countQ;
    if (flush) begin
      countD = '0;
    end else if (pushOk && !popOk) begin
      countD = countQ + CountW'(1);
    end else if (popOk && !pushOk) begin
      countD = countQ - CountW'(1);
    end
  end

  always_comb begin
    statusWord       = '0;
    statusWord[0]    = empty;
    statusWord[1]    = full;
    statusWord[2]    = overflowQ;
    statusWord[3]    = underflowQ;
    statusWord[15:8] = 8'(countQ);
    rdWord           = '0;
    case (bus.iUartAddr)
      AddrData:    if (!empty) rdWord = mem[rdPtrQ];
      AddrStatus:  rdWord = statusWord;
      AddrPushCnt: rdWord = pushCntQ;
      default:     rdWord = '0;
    endcase
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge iClock) begin
    if (pushOk) mem[wrPtrQ] <= bus.iFifoData;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      wrPtrQ     <= '0;
      rdPtrQ     <= '0;
      countQ     <= '0;
      pushCntQ   <= '0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
      selQ       <= 1'b0;
      armedQ     <= 1'b0;
      rdDataQ    <= '0;
      rdPendQ    <= 1'b0;
      uartDataQ  <= '0;
      fullQ      <= 1'b0;
      notEmptyQ  <= 1'b0;
    end else begin
      selQ    <= bus.iUartSelected;
      armedQ  <= armedQ | ~bus.iUartSelected;
      countQ  <= countD;
      rdPendQ <= rdStrobe;
      if (rdStrobe) rdDataQ <= rdWord;
      if (rdPendQ) uartDataQ <= rdDataQ;
      if (flush) begin
        wrPtrQ <= '0;
        rdPtrQ <= '0;
      end else begin
        if (pushOk) wrPtrQ <= wrPtrQ + DEPTH_LOG2'(1);
        if (popOk)  rdPtrQ <= rdPtrQ + DEPTH_LOG2'(1);
      end
      if (pushOk) pushCntQ <= pushCntQ + DATA_WIDTH'(1);
      overflowQ  <= (overflowQ & ~clear) | overflowSet;
      underflowQ <= (underflowQ & ~clear) | underflowSet;
      fullQ      <= (countD == CountW'(Depth));
      notEmptyQ  <= (countD != '0);
    end
  end

  assign bus.oUartData     = uartDataQ;
  assign bus.oFifoFull     = fullQ;
  assign bus.oFifoNotEmpty = notEmptyQ;

  logic unusedData;
  assign unusedData = ^bus.iUartData[DATA_WIDTH-1:2];
endmodule

// File: doc/rgu_result_fifo.md
# rgu_result_fifo

Receiving end of the Ray Generation Unit's result push path. Captures every word the RGU emits with `oFifoPush`/`oFifoData` into a circular buffer and lets the host drain it through the same UART register-access protocol the RGU already exposes (`iUartSelected`/`iUartWrite`/`iUartAddr`/`iUartData`/`oUartData`). Sits between the RGU and the UART host bridge, so `RGU_PUSH` results can be read back word by word.

## Interface
- `DATA_WIDTH`, 32: word width; matches `GPU_WORD`.
- `DEPTH_LOG2`, 4: log2 of buffer depth (16 entries); legal range 1..7.
- `iClock`  in  1  sole clock, rising edge.
- `iReset`  in  1  reset, synchronous, active-high.
- `iEnable`  in  1  push qualifier; when 0, `iFifoPush` is ignored. UART accesses are still served.
- `iFifoPush`  in  1  one-cycle write strobe from RGU `oFifoPush`.
- `iFifoData`  in  DATA_WIDTH  word to store, from RGU `oFifoData`.
- `iUartSelected`  in  1  host access select.
- `iUartWrite`  in  1  1 = register write, 0 = register read; sampled with select.
- `iUartAddr`  in  8  register address.
- `iUartData`  in  DATA_WIDTH  write data.
- `oUartData`  out  DATA_WIDTH  registered read data.
- `oFifoFull`  out  1  registered; count == depth.
- `oFifoNotEmpty`  out  1  registered; count != 0 (host attention line).

## Operation
- Buffer: `2**DEPTH_LOG2` words, write pointer, read pointer, count of `DEPTH_LOG2+1` bits. Pointers wrap modulo depth.
- Access strobe: one access per rising edge of `iUartSelected`. The strobe is the first cycle select is high, detected against a registered copy of select. Holding select high produces no further accesses.
- Register map, unknown addresses: reads return 0, writes are ignored.
  - 0x00 DATA (R): returns the head word and pops it. Reading while empty returns 0, leaves the buffer unchanged and sets sticky `underflow`.
  - 0x01 STATUS (R):
    - bit0 empty
    - bit1 full
    - bit2 overflow (sticky)
    - bit3 underflow (sticky)
    - bits[15:8] count, zero-extended
    - all other bits 0
  - 0x02 CONTROL (W):
    - bit0 flush: pointers and count go to 0; stored data is not cleared.
    - bit1 clear: clears the overflow and underflow flags.
    - Both bits may be set in one write.
  - 0x03 PUSHCNT (R): total words accepted since reset. DATA_WIDTH bits, wraps to 0. Flush does not reset it.
- Push acceptance:
  - Requires `iEnable & iFifoPush`.
  - Full with no pop in the same cycle: word is dropped, sticky `overflow` is set, PUSHCNT is unchanged.
- Simultaneous push and pop:
  - Non-empty: both happen; count unchanged.
  - Full: the push is accepted because the pop frees a slot; no overflow.
  - Empty: the pop underflows (returns 0, sets underflow) and the push is stored. No bypass.
- Flush and push in the same cycle: flush wins. The push is dropped, flagged neither as overflow nor counted.
- Flush and clear act on the cycle of the write strobe.

## Timing
- Reset, synchronous: pointers, count, PUSHCNT, both sticky flags, the select history register, `oUartData`, `oFifoFull` and `oFifoNotEmpty` all go to 0.
- Reset mid-operation discards buffer contents. A select held high across reset deassertion does not generate a strobe; only a new rising edge does.
- Read latency: a strobe at edge N makes `oUartData` valid after edge N+1. It holds that value until the next read strobe. Write strobes and idle cycles do not alter it.
- STATUS and PUSHCNT reads return the values from before the strobe cycle. They exclude any push or pop that lands on that same edge.
- `oFifoFull` and `oFifoNotEmpty` reflect the count after each edge, with one cycle of latency from push/pop.
- Throughput:
  - One push per cycle.
  - One pop per access; at least 2 cycles per access because select must deassert between accesses.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then do three DATA reads with select high for 3 cycles each -> `oUartData` = 0x11, 0x22, 0x33; exactly 3 pops; `oFifoNotEmpty` falls after the third pop; STATUS = 0x00000001.
- Push 17 words 0x100..0x110 with DEPTH_LOG2=4 -> `oFifoFull`=1; STATUS = 0x00001006; PUSHCNT = 16; draining returns 0x100..0x10F.
- Hold full, then issue a DATA strobe in the same cycle as a push of 0xAA -> returns the head word; count stays 16; no overflow; 0xAA is the last word drained.
- DATA read while empty, in the same cycle as a push of 0x55 -> `oUartData`=0; underflow=1; STATUS after = 0x00000108; next DATA read returns 0x55; CONTROL write 0x2 -> STATUS = 0x00000001.
- Push 5 words, write CONTROL 0x1 in the same cycle as a push of 0x77 -> count 0; `oFifoNotEmpty`=0; PUSHCNT = 5; no overflow.
- `iEnable`=0 with 4 pushes -> count 0, PUSHCNT 0. Assert `iReset` for one cycle with 3 words stored and select held high -> outputs 0, and no read occurs until select toggles.
